axi_mmio_console: RTL and testbench
===================================

# axi_mmio_console

AXI4-Lite slave peripheral that terminates the CPU's non-memory write/read traffic: console bytes and the test-status word. It sits downstream of the `picorv32_axi` master, alongside the main memory, behind the address decode. Console bytes written to `CONSOLE_ADDR` are buffered in a FIFO and drained on a byte stream. A write of `PASS_MAGIC` to `STATUS_ADDR` raises a sticky `tests_passed`.

## Interface
- `FIFO_DEPTH`, 16: console FIFO entries; power of two, at least 2.
- `CONSOLE_ADDR`, 32'h1000_0000: console TX register.
- `STATUS_ADDR`, 32'h2000_0000: test status register.
- `PASS_MAGIC`, 32'd123456789: value that sets `tests_passed`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_axi_awvalid` in 1, `mem_axi_awready` out 1, `mem_axi_awaddr` in 32, `mem_axi_awprot` in 3 (ignored): write address channel.
- `mem_axi_wvalid` in 1, `mem_axi_wready` out 1, `mem_axi_wdata` in 32, `mem_axi_wstrb` in 4: write data channel.
- `mem_axi_bvalid` out 1, `mem_axi_bready` in 1: write response; there is no resp field.
- `mem_axi_arvalid` in 1, `mem_axi_arready` out 1, `mem_axi_araddr` in 32, `mem_axi_arprot` in 3 (ignored): read address channel.
- `mem_axi_rvalid` out 1, `mem_axi_rready` in 1, `mem_axi_rdata` out 32: read data channel.
- `tx_valid` out 1, `tx_ready` in 1, `tx_data` out 8: console byte stream (valid/ready).
- `tests_passed` out 1: sticky pass flag.
- `bus_error` out 1: sticky; set by any access to an unmapped address.

## Operation
- Address match compares `addr[31:2]` only; `addr[1:0]` is ignored.
- Write path FSM has three states: W_IDLE, W_EXEC, W_RESP.
  - `awready = !aw_latched && state==W_IDLE`; `wready = !w_latched && state==W_IDLE`.
  - AW and W may arrive in either order or in the same cycle. Each is latched independently on its handshake.
  - W_IDLE → W_EXEC once both are latched.
- W_EXEC, console write:
  - If `wstrb[0]` is set and the FIFO is full, stay in W_EXEC. The stall lasts until a pop frees an entry.
  - Otherwise push `wdata[7:0]` when `wstrb[0]` is set, then → W_RESP.
  - If `wstrb[0]` is clear, push nothing and → W_RESP.
- W_EXEC, status write: if `wstrb==4'hF` and `wdata==PASS_MAGIC`, set `tests_passed`; otherwise no effect. Then → W_RESP.
- W_EXEC, unmapped write: data is dropped, `bus_error` is set, → W_RESP.
- W_RESP: `bvalid=1` until `bready`. On the handshake clear both latches and → W_IDLE.
- Read path FSM has two states: R_IDLE, R_RESP.
  - `arready = (rstate==R_IDLE)`. On the handshake, register `rdata` and → R_RESP with `rvalid=1`.
  - R_RESP holds `rvalid` and `rdata` stable until `rready`, then → R_IDLE.
- Read data by address:
  - STATUS: `{16'b0, level[7:0], 6'b0, bus_error, tests_passed}`.
  - CONSOLE: `{30'b0, fifo_empty, fifo_full}`.
  - Unmapped: 0, and set `bus_error`.
- The read and write paths are independent and may be active concurrently.
- Console FIFO is first-word fall-through:
  - `tx_valid = !empty`; `tx_data` = head entry.
  - Pop on `tx_valid && tx_ready`.
  - Pointers wrap modulo `FIFO_DEPTH`. `level` is a counter of width clog2(DEPTH)+1.
  - Push when full is blocked even if a pop occurs in the same cycle. The pushing write proceeds the following cycle.
  - Simultaneous push and pop when not full leaves `level` unchanged.

## Timing
- Reset values: awready=1, wready=1, arready=1; bvalid=0, rvalid=0, rdata=0, tx_valid=0, tests_passed=0, bus_error=0. FIFO is empty and both FSMs are idle.
- Write latency, no stall:
  - Second of AW/W handshakes in cycle N.
  - W_EXEC in N+1; the FIFO entry is visible on `tx_valid` in N+2.
  - `bvalid` high in N+2.
  - With `bready` held high, next `awready`/`wready` in N+3.
- Read latency: handshake in cycle N → `rvalid` in N+1. Back-to-back reads take 2 cycles each with `rready` held high.
- `tests_passed` and `bus_error` change at the end of the W_EXEC cycle. Status readback reflects them from the next cycle.
- Reset mid-transaction: all latches, FSMs and FIFO clear on the next edge, and the in-flight response is dropped. `bvalid`/`rvalid` are low the cycle after `reset` is sampled.

## Test plan
- Write 0x41 then 0x42 to 0x1000_0000 with `tx_ready=1` → `tx_data` 0x41 then 0x42. Each write sees `bvalid` 2 cycles after its handshake.
- `tx_ready=0`, 17 writes with FIFO_DEPTH=16 → the 17th write stalls with `bvalid=0`. Status read gives level=16. Assert `tx_ready` for one cycle → the stalled write completes and level returns to 16.
- Write 123456789 to 0x2000_0000 with wstrb=F → `tests_passed=1`. A later write of 5 leaves it 1. Write 123456789 with wstrb=7 on a fresh reset → stays 0.
- W valid 3 cycles before AW, with `bready` low for 4 cycles → one response only, `bvalid` stable throughout, no duplicate push.
- Read 0x3000_0000 → `rdata=0`, `bus_error=1`. Then a status read returns bit1=1.
- Assert `reset` while in W_EXEC stalled on a full FIFO → next cycle `bvalid=0`, `tx_valid=0`, awready=1, level=0.

Source files
------------

// File: rtl/axi_mmio_console.sv
// AXI4-Lite MMIO sink for CPU console bytes and the test-status word.
// Console writes are queued in a first-word-fall-through FIFO drained on a byte stream.
module axi_mmio_console #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tests_passed,
  output logic        bus_error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic        aw_latched, w_latched;
  logic [29:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_console, wr_status, wr_unmapped;
  logic        exec_stall;

  logic [29:0] rd_addr;
  logic [31:0] rd_value;
  logic        rd_unmapped;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    level8;
  logic          fifo_empty, fifo_full, push, pop;

  logic unused_bits;
  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

  assign mem_axi_awready = !aw_latched && (wstate == W_IDLE);
  assign mem_axi_wready  = !w_latched && (wstate == W_IDLE);
  assign mem_axi_bvalid  = (wstate == W_RESP);
  assign aw_hs = mem_axi_awvalid && mem_axi_awready;
  assign w_hs  = mem_axi_wvalid && mem_axi_wready;

  assign wr_console  = (aw_addr_q == CONSOLE_ADDR[31:2]);
  assign wr_status   = (aw_addr_q == STATUS_ADDR[31:2]);
  assign wr_unmapped = !wr_console && !wr_status;

  // A full FIFO blocks the push even if a pop lands in the same cycle.
  assign exec_stall = (wstate == W_EXEC) && wr_console && w_strb_q[0] && fifo_full;
  assign push       = (wstate == W_EXEC) && wr_console && w_strb_q[0] && !fifo_full;
  assign pop        = !fifo_empty && tx_ready;

  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE:  if ((aw_latched || aw_hs) && (w_latched || w_hs)) wstate_nx = W_EXEC;
      W_EXEC:  if (!exec_stall) wstate_nx = W_RESP;
      W_RESP:  if (mem_axi_bready) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate       <= W_IDLE;
      aw_latched   <= 1'b0;
      w_latched    <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      tests_passed <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      wstate <= wstate_nx;
      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_addr_q  <= mem_axi_awaddr[31:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        w_data_q  <= mem_axi_wdata;
        w_strb_q  <= mem_axi_wstrb;
      end
      if ((wstate == W_RESP) && mem_axi_bready) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
      end
      if ((wstate == W_EXEC) && wr_status && (w_strb_q == 4'hF) && (w_data_q == PASS_MAGIC))
        tests_passed <= 1'b1;
      if (((wstate == W_EXEC) && wr_unmapped) || (ar_hs && rd_unmapped))
        bus_error <= 1'b1;
    end
  end

  assign mem_axi_arready = (rstate == R_IDLE);
  assign mem_axi_rvalid  = (rstate == R_RESP);
  assign ar_hs   = mem_axi_arvalid && mem_axi_arready;
  assign rd_addr = mem_axi_araddr[31:2];
  assign level8  = 8'(level);

  always_comb begin
    rd_value    = 32'h0;
    rd_unmapped = 1'b0;
    if (rd_addr == STATUS_ADDR[31:2])
      rd_value = {16'h0, level8, 6'h0, bus_error, tests_passed};
    else if (rd_addr == CONSOLE_ADDR[31:2])
      rd_value = {30'h0, fifo_empty, fifo_full};
    else
      rd_unmapped = 1'b1;
  end

  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nx = R_RESP;
      R_RESP:  if (mem_axi_rready) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate        <= R_IDLE;
      mem_axi_rdata <= 32'h0;
    end else begin
      rstate <= rstate_nx;
      if (ar_hs) mem_axi_rdata <= rd_value;
    end
  end

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= w_data_q[7:0];
  end

endmodule

// File: tb/tb_axi_mmio_console.sv
// Bench for axi_mmio_console: vector table, directed corner sequences and
// randomized traffic checked against a queue-based model of the peripheral.
module tb_axi_mmio_console;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CON   = 32'h1000_0000;
  localparam logic [31:0] STA   = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_axi_awvalid = 1'b0, mem_axi_awready;
  logic [31:0] mem_axi_awaddr = '0;
  logic [2:0]  mem_axi_awprot = '0;
  logic        mem_axi_wvalid = 1'b0, mem_axi_wready;
  logic [31:0] mem_axi_wdata = '0;
  logic [3:0]  mem_axi_wstrb = '0;
  logic        mem_axi_bvalid, mem_axi_bready = 1'b1;
  logic        mem_axi_arvalid = 1'b0, mem_axi_arready;
  logic [31:0] mem_axi_araddr = '0;
  logic [2:0]  mem_axi_arprot = '0;
  logic        mem_axi_rvalid, mem_axi_rready = 1'b1;
  logic [31:0] mem_axi_rdata;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tests_passed, bus_error;

  int total = 0;
  int bad = 0;
  bit rand_tx = 1'b0;

  // Reference model: pass flag, error flag and the bytes the FIFO should hold.
  bit         m_tp = 1'b0, m_be = 1'b0;
  logic [7:0] mq[$];

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_tp;
    bit          exp_be;
  } vec_t;
  vec_t tbl[11];

  axi_mmio_console dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tests_passed(tests_passed), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_unmapped(input logic [31:0] a);
    return (a[31:2] != CON[31:2]) && (a[31:2] != STA[31:2]);
  endfunction

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(mq.size()), 6'h0, m_be, m_tp};
  endfunction

  function automatic logic [31:0] exp_console();
    return {30'h0, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  // Every byte leaving the stream must be the oldest byte the model holds.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (mq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected_byte: got %h expected no byte", tx_data);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(mq.pop_front()));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_tx) tx_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_bready = 1'b1;
    mem_axi_rready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_tp = 1'b0;
    m_be = 1'b0;
  endtask

  // Full write transaction; lat = cycles from the last address/data handshake to bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 1'b0;
    w_done = 1'b0;
    lat = -1;
    if (a[31:2] == CON[31:2] && s[0]) mq.push_back(d[7:0]);
    if (a[31:2] == STA[31:2] && s == 4'hF && d == MAGIC) m_tp = 1'b1;
    if (is_unmapped(a)) m_be = 1'b1;
    mem_axi_awaddr = a;
    mem_axi_wdata = d;
    mem_axi_wstrb = s;
    mem_axi_awvalid = 1'b1;
    mem_axi_wvalid = 1'b1;
    mem_axi_bready = 1'b1;
    n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      hs_aw = mem_axi_awvalid && mem_axi_awready;
      hs_w = mem_axi_wvalid && mem_axi_wready;
      @(posedge clk);
      #1;
      n++;
      if (hs_aw) begin aw_done = 1'b1; mem_axi_awvalid = 1'b0; end
      if (hs_w) begin w_done = 1'b1; mem_axi_wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      mem_axi_awvalid = 1'b0;
      mem_axi_wvalid = 1'b0;
      chk("write_accept_timeout", 32'(aw_done && w_done), 1);
      return;
    end
    n = 1;
    while (!mem_axi_bvalid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mem_axi_bvalid) begin
      chk("write_resp_timeout", 32'(mem_axi_bvalid), 1);
      return;
    end
    lat = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    n = 0;
    mem_axi_araddr = a;
    mem_axi_arvalid = 1'b1;
    mem_axi_rready = 1'b1;
    while (!mem_axi_arready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    mem_axi_arvalid = 1'b0;
    chk("read_rvalid_next_cycle", 32'(mem_axi_rvalid), 1);
    d = mem_axi_rdata;
    @(posedge clk);
    #1;
    chk("read_rvalid_dropped", 32'(mem_axi_rvalid), 0);
    if (is_unmapped(a)) m_be = 1'b1;
  endtask

  // Issue AW and W together in one cycle without waiting for the response.
  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_axi_awaddr = a;
    mem_axi_wdata = d;
    mem_axi_wstrb = s;
    mem_axi_awvalid = 1'b1;
    mem_axi_wvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid = 1'b0;
  endtask

  initial begin
    int lat, n, op, sz;
    logic [31:0] rd, a, d;
    logic [3:0] s;
    bit stable;

    tbl[0]  = '{1'b0, STA,            MAGIC,      4'h7, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, STA,            32'h0,      4'h0, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, STA,            MAGIC,      4'hF, 32'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, STA,            32'h0,      4'h0, 32'h1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, STA,            32'd5,      4'hF, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, CON,            32'h0,      4'h0, 32'h2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'h3000_0000,  32'h0,      4'h0, 32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, STA,            32'h0,      4'h0, 32'h3, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'h2000_0003,  MAGIC,      4'hF, 32'h0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h4000_0000,  32'h1234,   4'hF, 32'h0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 32'h1000_0001,  32'h0,      4'h0, 32'h2, 1'b1, 1'b1};

    do_reset();
    chk("reset_handshake_flags",
        32'({mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_bvalid,
             mem_axi_rvalid, tx_valid, tests_passed, bus_error}), 32'hE0);
    chk("reset_rdata", mem_axi_rdata, 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rd) begin
        do_read(tbl[i].addr, rd);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      end else begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, lat);
        chk($sformatf("tbl%0d_wlat", i), lat, 2);
      end
      chk($sformatf("tbl%0d_tests_passed", i), 32'(tests_passed), 32'(tbl[i].exp_tp));
      chk($sformatf("tbl%0d_bus_error", i), 32'(bus_error), 32'(tbl[i].exp_be));
    end

    // Two console bytes streamed straight out.
    do_reset();
    tx_ready = 1'b1;
    do_write(CON, 32'h41, 4'h1, lat);
    chk("con41_latency", lat, 2);
    do_write(CON, 32'h42, 4'h1, lat);
    chk("con42_latency", lat, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("con_bytes_drained", mq.size(), 0);

    // Fill the FIFO, then a 17th write must stall until one byte drains.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(CON, 32'h60 + i, 4'h1, lat);
      chk("fill_latency", lat, 2);
    end
    mq.push_back(8'hAA);
    start_write(CON, 32'hAA, 4'h1);
    stable = 1'b1;
    repeat (3) begin
      if (mem_axi_bvalid) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("stall_no_bvalid", 32'(stable), 1);
    do_read(STA, rd);
    chk("stall_level_16", 32'(rd[15:8]), 16);
    chk("stall_still_no_bvalid", 32'(mem_axi_bvalid), 0);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    n = 0;
    while (!mem_axi_bvalid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_released_bvalid", 32'(mem_axi_bvalid), 1);
    @(posedge clk);
    #1;
    chk("stall_released_awready", 32'(mem_axi_awready), 1);
    do_read(STA, rd);
    chk("stall_level_back_16", rd, exp_status());

    // Reset while the write path is stalled on a full FIFO.
    start_write(CON, 32'hBB, 4'h1);
    @(posedge clk);
    #1;
    chk("pre_reset_stalled", 32'(mem_axi_bvalid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_flags", 32'({mem_axi_bvalid, tx_valid, mem_axi_awready, mem_axi_wready}), 32'h3);
    reset = 1'b0;
    mq.delete();
    m_tp = 1'b0;
    m_be = 1'b0;
    do_read(STA, rd);
    chk("midreset_level_0", rd, 0);

    // W arrives three cycles before AW, and bready is held low for four cycles.
    do_reset();
    tx_ready = 1'b0;
    mem_axi_bready = 1'b0;
    mq.push_back(8'h55);
    mem_axi_wdata = 32'h55;
    mem_axi_wstrb = 4'h1;
    mem_axi_awaddr = CON;
    mem_axi_wvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_axi_wvalid = 1'b0;
    chk("early_w_wready_low", 32'(mem_axi_wready), 0);
    repeat (2) @(posedge clk);
    #1;
    mem_axi_awvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_axi_awvalid = 1'b0;
    chk("early_w_exec_no_bvalid", 32'(mem_axi_bvalid), 0);
    @(posedge clk);
    #1;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!mem_axi_bvalid) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("early_w_bvalid_held", 32'(stable & mem_axi_bvalid), 1);
    mem_axi_bready = 1'b1;
    @(posedge clk);
    #1;
    stable = 1'b1;
    repeat (4) begin
      if (mem_axi_bvalid) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("early_w_single_response", 32'(stable), 1);
    do_read(STA, rd);
    chk("early_w_single_push", rd, exp_status());

    // Randomized traffic with a randomly stalling byte consumer.
    do_reset();
    rand_tx = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5 || op == 9) begin
        if (op <= 4) begin
          a = CON | 32'($urandom_range(0, 3));
          d = $urandom;
          s = 4'($urandom_range(0, 15));
        end else if (op == 5) begin
          a = STA;
          d = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
          s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        end else begin
          a = ($urandom_range(0, 1) == 1) ? 32'h1000_0004 : (32'h4000_0000 | ($urandom & 32'h0FFF_FFFF));
          d = $urandom;
          s = 4'($urandom_range(0, 15));
        end
        sz = mq.size();
        do_write(a, d, s, lat);
        if (!(a[31:2] == CON[31:2] && s[0] && sz >= DEPTH))
          chk("rand_write_latency", lat, 2);
        chk("rand_flags", 32'({tests_passed, bus_error}), 32'({m_tp, m_be}));
      end else begin
        rand_tx = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        if (op == 6) begin
          do_read(STA | 32'($urandom_range(0, 3)), rd);
          chk("rand_status_read", rd, exp_status());
        end else if (op == 7) begin
          do_read(CON, rd);
          chk("rand_console_read", rd, exp_console());
        end else begin
          do_read(32'h3000_0000 | ($urandom & 32'h00FF_FFFF), rd);
          chk("rand_unmapped_read", rd, 0);
          chk("rand_unmapped_be", 32'(bus_error), 1);
        end
        rand_tx = 1'b1;
      end
    end

    rand_tx = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_model_empty", mq.size(), 0);
    chk("drain_tx_valid_low", 32'(tx_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
